irq_pend_ctrl8: RTL and testbench

//  Upstream stage of the 8-to-3 priority-encode path. Synchronises 8 asynchronous request lines,

---
 rtl/irq_pend_ctrl8_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 38 +++
 rtl/irq_pend_ctrl8.sv | 91 +++++++++
 tb/tb_irq_pend_ctrl8.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pend_ctrl8_pkg.sv
// ---------------------------------------------------------------------------
// irq_pend_ctrl8_pkg : shared sizes and reset constants for irq_pend_ctrl8
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package irq_pend_ctrl8_pkg;
  localparam int            N_REQ    = 8;
  localparam int            ID_W     = 3;
  localparam logic [N_REQ-1:0] MASK_RST = 8'hFF;
endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge : one request line synchroniser with optional rising-edge detect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  output logic o_event
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // History starts at 0 so a line already high at reset release yields one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
      r_prev <= w_sync_out;
    end
  end

  assign o_event = (EDGE_MODE != 0) ? (w_sync_out & ~r_prev) : w_sync_out;

endmodule

`default_nettype wire

// File: rtl/irq_pend_ctrl8.sv
// ---------------------------------------------------------------------------
// irq_pend_ctrl8 : sticky masked pending bits feeding a registered
//                  highest-index valid/ready presenter, with overflow flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_pend_ctrl8
  import irq_pend_ctrl8_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             mask_wr,
  input  logic [N_REQ-1:0] mask_din,
  output logic [N_REQ-1:0] mask_q,
  output logic [N_REQ-1:0] pend_q,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ready,
  output logic [N_REQ-1:0] ovf_q,
  input  logic             ovf_clr
);

  logic [N_REQ-1:0] w_event;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_sel;
  logic             w_hs;

  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] r_mask;
  logic [N_REQ-1:0] r_ovf;
  logic             r_valid;
  logic [ID_W-1:0]  r_id;

  function automatic logic [ID_W-1:0] f_top_idx(input logic [N_REQ-1:0] v);
    f_top_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) f_top_idx = ID_W'(i);
    end
  endfunction

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_line
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
      ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_in[g]),
        .o_event (w_event[g])
      );
    end
  endgenerate

  assign w_hs  = r_valid & irq_ready;
  assign w_clr = w_hs ? (N_REQ'(1) << r_id) : '0;
  // The bit being acknowledged must not be re-presented on a back-to-back grant.
  assign w_sel = pend_q & ~w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_mask  <= MASK_RST;
      r_ovf   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_event;
      r_ovf  <= (ovf_clr ? '0 : r_ovf) | (w_event & r_pend & ~w_clr);
      if (mask_wr) r_mask <= mask_din;
      if (!r_valid || w_hs) begin
        r_valid <= |w_sel;
        r_id    <= f_top_idx(w_sel);
      end
    end
  end

  assign mask_q    = r_mask;
  assign pend_q    = r_pend & r_mask;
  assign ovf_q     = r_ovf;
  assign irq_valid = r_valid;
  assign irq_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_irq_pend_ctrl8.sv
// ---------------------------------------------------------------------------
// tb_irq_pend_ctrl8 : edge-mode and level-mode instances against a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_irq_pend_ctrl8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req_in = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_din = 8'hFF;
  logic       irq_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [7:0] mask_o [2];
  logic [7:0] pend_o [2];
  logic       valid_o [2];
  logic [2:0] id_o [2];
  logic [7:0] ovf_o [2];

  int n_chk = 0;
  int n_pass = 0;

  // index 0: rising-edge events, index 1: level events
  irq_pend_ctrl8 #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_dut_edge (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_wr(mask_wr), .mask_din(mask_din),
    .mask_q(mask_o[0]), .pend_q(pend_o[0]), .irq_valid(valid_o[0]), .irq_id(id_o[0]),
    .irq_ready(irq_ready), .ovf_q(ovf_o[0]), .ovf_clr(ovf_clr)
  );

  irq_pend_ctrl8 #(.SYNC_STAGES(2), .EDGE_MODE(0)) u_dut_lvl (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_wr(mask_wr), .mask_din(mask_din),
    .mask_q(mask_o[1]), .pend_q(pend_o[1]), .irq_valid(valid_o[1]), .irq_id(id_o[1]),
    .irq_ready(irq_ready), .ovf_q(ovf_o[1]), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_dly[$];
  logic [7:0] m_prev;
  logic [7:0] m_mask;
  logic [7:0] m_pend [2];
  logic [7:0] m_ovf [2];
  logic       m_valid [2];
  int         m_id [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_dly = '{8'h00, 8'h00};
    m_prev = '0;
    m_mask = 8'hFF;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_ovf[m] = '0; m_valid[m] = 1'b0; m_id[m] = 0;
    end
  endtask

  task automatic compare_all(input string ph);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_mask", ph, m), 32'(mask_o[m]), 32'(m_mask));
      chk($sformatf("%s_m%0d_pend", ph, m), 32'(pend_o[m]), 32'(m_pend[m] & m_mask));
      chk($sformatf("%s_m%0d_valid", ph, m), 32'(valid_o[m]), 32'(m_valid[m]));
      chk($sformatf("%s_m%0d_ovf", ph, m), 32'(ovf_o[m]), 32'(m_ovf[m]));
      if (m_valid[m]) chk($sformatf("%s_m%0d_id", ph, m), 32'(id_o[m]), 32'(m_id[m]));
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string ph);
    logic [7:0] seen, ev, ack, sel;
    @(posedge clk);
    seen = m_dly.pop_front();
    m_dly.push_back(req_in);
    for (int m = 0; m < 2; m++) begin
      ev  = (m == 0) ? (seen & ~m_prev) : seen;
      ack = (m_valid[m] && irq_ready) ? (8'h01 << m_id[m]) : 8'h00;
      m_ovf[m] = (ovf_clr ? 8'h00 : m_ovf[m]) | (ev & m_pend[m] & ~ack);
      sel = m_pend[m] & m_mask & ~ack;
      m_pend[m] = (m_pend[m] & ~ack) | ev;
      if (!m_valid[m] || ack != 0) begin
        m_valid[m] = (sel != 0);
        m_id[m]    = top_bit(sel);
      end
    end
    m_prev = seen;
    if (mask_wr) m_mask = mask_din;
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic do_reset(input string ph);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({ph, "_async"});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // T1: reset values, single pulse on bit 5
    do_reset("t1");
    req_in = 8'h20; step("t1");
    req_in = 8'h00; step("t1");
    step("t1");
    chk("t1_pend20", 32'(pend_o[0]), 32'h20);
    step("t1");
    chk("t1_valid", 32'(valid_o[0]), 32'h1);
    chk("t1_id5", 32'(id_o[0]), 32'h5);
    irq_ready = 1'b1;
    repeat (2) step("t1");

    // T2: two simultaneous lines granted back to back
    req_in = 8'h81; step("t2");
    req_in = 8'h00; repeat (2) step("t2");
    step("t2");
    chk("t2_id7", 32'(id_o[0]), 32'h7);
    step("t2");
    chk("t2_id0", 32'(id_o[0]), 32'h0);
    step("t2");
    chk("t2_idle", 32'(valid_o[0]), 32'h0);

    // T3: held index survives a higher arrival
    irq_ready = 1'b0;
    req_in = 8'h04; step("t3");
    req_in = 8'h00; repeat (3) step("t3");
    req_in = 8'h40; step("t3");
    req_in = 8'h00; repeat (4) step("t3");
    chk("t3_hold2", 32'(id_o[0]), 32'h2);
    irq_ready = 1'b1; step("t3");
    chk("t3_next6", 32'(id_o[0]), 32'h6);
    repeat (2) step("t3");

    // T4: overflow, clear, and event coinciding with ack
    irq_ready = 1'b0;
    req_in = 8'h08; step("t4");
    req_in = 8'h00; repeat (4) step("t4");
    req_in = 8'h08; step("t4");
    req_in = 8'h00; repeat (3) step("t4");
    chk("t4_ovf", 32'(ovf_o[0]), 32'h08);
    ovf_clr = 1'b1; step("t4");
    ovf_clr = 1'b0;
    chk("t4_ovfclr", 32'(ovf_o[0]), 32'h0);
    req_in = 8'h08; step("t4");
    req_in = 8'h00; step("t4");
    irq_ready = 1'b1; step("t4");
    irq_ready = 1'b0; repeat (2) step("t4");
    irq_ready = 1'b1; repeat (3) step("t4");

    // T5: masked event is latched but hidden until unmasked
    mask_din = 8'hFE; mask_wr = 1'b1; step("t5");
    mask_wr = 1'b0;
    req_in = 8'h01; step("t5");
    req_in = 8'h00; repeat (3) step("t5");
    chk("t5_masked", 32'(valid_o[0]), 32'h0);
    mask_din = 8'hFF; mask_wr = 1'b1; step("t5");
    mask_wr = 1'b0; step("t5");
    chk("t5_unmasked", 32'(valid_o[0]), 32'h1);
    repeat (2) step("t5");

    // T6: reset mid-handshake with a held line, then a held line acked in level mode
    irq_ready = 1'b0;
    req_in = 8'h04; repeat (4) step("t6");
    req_in = 8'h10;
    do_reset("t6");
    repeat (4) step("t6");
    irq_ready = 1'b1; repeat (6) step("t6");
    req_in = 8'h00; repeat (4) step("t6");

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) req_in = 8'($urandom & $urandom);
      mask_wr   = ($urandom_range(0, 15) == 0);
      mask_din  = 8'($urandom | $urandom);
      irq_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 11) == 0);
      if (c == 1000) do_reset("rnd");
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
